// File: rtl/poly_tone_mixer.sv
// rtl/poly_tone_mixer.sv - multi-voice square-wave tone mixer between audio input and output FIFOs
// Define MIX_SATURATE_EN to clamp the mixed sample instead of wrapping it.
module poly_tone_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 19,
  parameter int SAMPLE_W   = 32,
  parameter int AMPLITUDE  = 100000000
) (
  input  logic                           CLOCK_50,
  input  logic                           reset_n,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [NUM_VOICES*PERIOD_W-1:0] voice_half_period,
  input  logic [SAMPLE_W-1:0]            left_channel_audio_in,
  input  logic [SAMPLE_W-1:0]            right_channel_audio_in,
  input  logic                           audio_in_available,
  input  logic                           audio_out_allowed,
  output logic                           read_audio_in,
  output logic [SAMPLE_W-1:0]            left_channel_audio_out,
  output logic [SAMPLE_W-1:0]            right_channel_audio_out,
  output logic                           write_audio_out,
  output logic [3:0]                     active_voices
);

  localparam int SW = SAMPLE_W + 4;
  localparam logic signed [SW-1:0] AMP     = SW'(AMPLITUDE);
  localparam logic signed [SW-1:0] SAT_MAX = {{5{1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{5{1'b1}}, {(SAMPLE_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MIX   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [PERIOD_W-1:0]   r_cnt [NUM_VOICES];
  logic [PERIOD_W-1:0]   r_per [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_phase;
  logic [NUM_VOICES-1:0] w_sounding;
  logic signed [SW-1:0]  w_sum;
  logic [3:0]            w_count;
  logic [3:0]            r_active;

  logic [1:0]            r_state;
  logic                  r_read;
  logic                  r_write;
  logic [SAMPLE_W-1:0]   r_in_l;
  logic [SAMPLE_W-1:0]   r_in_r;
  logic signed [SW-1:0]  r_snap;
  logic [SAMPLE_W-1:0]   r_out_l;
  logic [SAMPLE_W-1:0]   r_out_r;
  logic signed [SW-1:0]  w_wide_l;
  logic signed [SW-1:0]  w_wide_r;

  always_comb begin
    w_sounding = '0;
    w_sum      = '0;
    w_count    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_sounding[i] = voice_en[i] && (r_per[i] != '0);
      if (w_sounding[i]) begin
        w_sum   = r_phase[i] ? (w_sum + AMP) : (w_sum - AMP);
        w_count = w_count + 4'd1;
      end
    end
  end

  // A new half-period is only adopted at a toggle boundary, so retuning never truncates a half-cycle.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_cnt[i] <= '0;
        r_per[i] <= '0;
      end
      r_phase  <= '0;
      r_active <= '0;
    end else begin
      r_active <= w_count;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (!voice_en[i]) begin
          r_cnt[i]   <= '0;
          r_phase[i] <= 1'b0;
          r_per[i]   <= voice_half_period[i*PERIOD_W +: PERIOD_W];
        end else if (r_per[i] == '0) begin
          r_cnt[i] <= '0;
          r_per[i] <= voice_half_period[i*PERIOD_W +: PERIOD_W];
        end else if (r_cnt[i] == r_per[i]) begin
          r_cnt[i]   <= '0;
          r_phase[i] <= ~r_phase[i];
          r_per[i]   <= voice_half_period[i*PERIOD_W +: PERIOD_W];
        end else begin
          r_cnt[i] <= r_cnt[i] + PERIOD_W'(1);
        end
      end
    end
  end

  function automatic logic [SAMPLE_W-1:0] reduce(input logic signed [SW-1:0] v);
`ifdef MIX_SATURATE_EN
    if (v > SAT_MAX)
      return SAT_MAX[SAMPLE_W-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[SAMPLE_W-1:0];
    else
      return v[SAMPLE_W-1:0];
`else
    return v[SAMPLE_W-1:0];
`endif
  endfunction

  assign w_wide_l = $signed({{4{r_in_l[SAMPLE_W-1]}}, r_in_l}) + r_snap;
  assign w_wide_r = $signed({{4{r_in_r[SAMPLE_W-1]}}, r_in_r}) + r_snap;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_in_l  <= '0;
      r_in_r  <= '0;
      r_snap  <= '0;
      r_out_l <= '0;
      r_out_r <= '0;
    end else begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (audio_in_available && audio_out_allowed) begin
            r_read  <= 1'b1;
            r_in_l  <= left_channel_audio_in;
            r_in_r  <= right_channel_audio_in;
            r_snap  <= w_sum;
            r_state <= S_MIX;
          end
        end
        S_MIX: begin
          r_out_l <= reduce(w_wide_l);
          r_out_r <= reduce(w_wide_r);
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (audio_out_allowed) begin
            r_write <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_audio_in           = r_read;
  assign write_audio_out         = r_write;
  assign left_channel_audio_out  = r_out_l;
  assign right_channel_audio_out = r_out_r;
  assign active_voices           = r_active;

endmodule

// File: tb/tb_poly_tone_mixer.sv
// tb/tb_poly_tone_mixer.sv - randomized self-checking bench for poly_tone_mixer against a behavioural model
module tb_poly_tone_mixer;

  localparam int NV  = 4;
  localparam int PW  = 19;
  localparam int SWD = 32;
  localparam longint AMP = 100000000;

  logic              CLOCK_50 = 1'b0;
  logic              reset_n;
  logic [NV-1:0]     voice_en;
  logic [NV*PW-1:0]  voice_half_period;
  logic [SWD-1:0]    left_in, right_in;
  logic              avail, allowed;
  logic              read_audio_in, write_audio_out;
  logic [SWD-1:0]    left_out, right_out;
  logic [3:0]        active_voices;

  int checks = 0;
  int errors = 0;

  poly_tone_mixer dut (
    .CLOCK_50               (CLOCK_50),
    .reset_n                (reset_n),
    .voice_en               (voice_en),
    .voice_half_period      (voice_half_period),
    .left_channel_audio_in  (left_in),
    .right_channel_audio_in (right_in),
    .audio_in_available     (avail),
    .audio_out_allowed      (allowed),
    .read_audio_in          (read_audio_in),
    .left_channel_audio_out (left_out),
    .right_channel_audio_out(right_out),
    .write_audio_out        (write_audio_out),
    .active_voices          (active_voices)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference voices: how many clocks into the current half-cycle, which half, and the adopted period.
  int     m_cnt [NV];
  int     m_per [NV];
  bit     m_phase [NV];
  int     m_stage;
  longint m_cap_l, m_cap_r, m_snap;
  longint e_left, e_right;
  int     e_active;
  bit     e_read, e_write;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint mix_reduce(input longint v);
    longint lo = -(64'sd1 <<< (SWD-1));
    longint hi = (64'sd1 <<< (SWD-1)) - 1;
`ifdef MIX_SATURATE_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    int t = int'(v);
    return longint'(t);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_cnt[i] = 0; m_per[i] = 0; m_phase[i] = 0;
    end
    m_stage = 0; m_cap_l = 0; m_cap_r = 0; m_snap = 0;
    e_left = 0; e_right = 0; e_active = 0; e_read = 0; e_write = 0;
  endtask

  // Predicts what the DUT shows after the coming rising edge, given the inputs now applied.
  task automatic model_edge();
    longint s = 0;
    int     n = 0;
    int     p_in;
    for (int i = 0; i < NV; i++)
      if (voice_en[i] && m_per[i] != 0) begin
        s += m_phase[i] ? AMP : -AMP;
        n++;
      end
    e_active = n;
    e_read   = 0;
    e_write  = 0;
    if (m_stage == 0) begin
      if (avail && allowed) begin
        e_read  = 1;
        m_cap_l = longint'($signed(left_in));
        m_cap_r = longint'($signed(right_in));
        m_snap  = s;
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      e_left  = mix_reduce(m_cap_l + m_snap);
      e_right = mix_reduce(m_cap_r + m_snap);
      m_stage = 2;
    end else if (allowed) begin
      e_write = 1;
      m_stage = 0;
    end
    for (int i = 0; i < NV; i++) begin
      p_in = int'(voice_half_period[i*PW +: PW]);
      if (!voice_en[i]) begin
        m_cnt[i] = 0; m_phase[i] = 0; m_per[i] = p_in;
      end else if (m_per[i] == 0) begin
        m_cnt[i] = 0; m_per[i] = p_in;
      end else if (m_cnt[i] == m_per[i]) begin
        m_cnt[i] = 0; m_phase[i] = !m_phase[i]; m_per[i] = p_in;
      end else begin
        m_cnt[i]++;
      end
    end
  endtask

  task automatic compare_all();
    check("read", longint'(read_audio_in), longint'(e_read));
    check("write", longint'(write_audio_out), longint'(e_write));
    check("active", longint'(active_voices), longint'(e_active));
    check("left", longint'($signed(left_out)), e_left);
    check("right", longint'($signed(right_out)), e_right);
  endtask

  task automatic step();
    model_edge();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    compare_all();
  endtask

  task automatic set_period(input int v, input int p);
    voice_half_period[v*PW +: PW] = PW'(p);
  endtask

  initial begin
    reset_n = 1'b0;
    voice_en = '0;
    voice_half_period = '0;
    left_in = '0; right_in = '0;
    avail = 1'b1; allowed = 1'b1;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    compare_all();
    reset_n = 1'b1;

    // Single voice, half-period 3, silent input, flags held high.
    voice_en = 4'b0001;
    set_period(0, 3);
    repeat (40) step();

    // Retune voice 0 from 9 to 2 mid half-cycle.
    set_period(0, 9);
    repeat (14) step();
    set_period(0, 2);
    repeat (30) step();

    // Two matched voices with a small input; output back-pressure during MIX/WRITE.
    voice_en = 4'b0000;
    step();
    voice_en = 4'b0011;
    set_period(0, 5); set_period(1, 5);
    left_in = 32'd5; right_in = 32'd7;
    for (int k = 0; k < 12; k++) begin
      allowed = (k % 6) < 2;
      repeat (3) step();
    end
    allowed = 1'b1;

    // Zero periods with every voice enabled: pass-through.
    voice_en = 4'b1111;
    for (int i = 0; i < NV; i++) set_period(i, 0);
    left_in = 32'h1234_5678; right_in = 32'hFFFF_FF00;
    repeat (12) step();

    // Overflow region in both directions.
    voice_en = 4'b0011;
    set_period(0, 4); set_period(1, 4);
    left_in = 32'd2147483000;
    right_in = -32'sd2147483000;
    repeat (60) step();

    // Reset while waiting in WRITE.
    avail = 1'b1; allowed = 1'b1;
    while (m_stage != 0) step();
    step();
    allowed = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    allowed = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (2) begin
      @(negedge CLOCK_50);
      compare_all();
    end
    reset_n = 1'b1;
    repeat (6) step();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) voice_en = NV'($urandom);
      if ($urandom_range(0, 19) == 0) set_period($urandom_range(0, NV-1), $urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0)
        left_in = ($urandom_range(0, 3) == 0) ? 32'd2147483000 : $urandom;
      if ($urandom_range(0, 3) == 0)
        right_in = ($urandom_range(0, 3) == 0) ? 32'h8000_0100 : $urandom;
      avail   = $urandom_range(0, 4) != 0;
      allowed = $urandom_range(0, 4) != 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
